// File: rtl/down_counter_reload.sv
// rtl/down_counter_reload.sv - loadable down-counter/timer with terminal-count pulse and auto-reload
// Optional prescaler enabled by defining PRESCALE_EN.
module down_counter_reload #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             tc_pulse,
  output logic             busy
);

  if (WIDTH < 2 || PRESCALE < 1) begin : g_bad_params
    $error("down_counter_reload: WIDTH must be >= 2 and PRESCALE >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic             tc_n;
  logic             busy_n;
  logic             step;

`ifdef PRESCALE_EN
  localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre, pre_n;

  // Decrement strobe: last enabled cycle of each PRESCALE-long window.
  assign step = (pre == PRE_LAST);

  always_comb begin
    pre_n = pre;
    if (load) begin
      pre_n = '0;
    end else if (state == RUN && enable) begin
      pre_n = step ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else begin
      pre <= pre_n;
    end
  end
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (load) begin
      count_n  = data_in;
      reload_n = data_in;
      if (data_in == '0) begin
        state_n = DONE;
      end else if (enable) begin
        state_n = RUN;
      end else begin
        state_n = HOLD;
      end
    end else begin
      case (state)
        RUN: begin
          if (!enable) begin
            state_n = HOLD;
          end else if (step) begin
            if (count > ONE) begin
              count_n = count - ONE;
            end else if (count == ONE) begin
              tc_n = 1'b1;
              if (auto_reload) begin
                count_n = reload_reg;
              end else begin
                count_n = '0;
                state_n = DONE;
              end
            end else begin
              // Unreachable in normal use; never wrap below zero.
              state_n = DONE;
            end
          end
        end
        HOLD: begin
          if (enable) begin
            state_n = RUN;
          end
        end
        default: begin
        end
      endcase
    end
    busy_n = (state_n == RUN) || (state_n == HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      tc_pulse   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      tc_pulse   <= tc_n;
      busy       <= busy_n;
    end
  end

  assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_reload.sv
// tb/tb_down_counter_reload.sv - self-checking bench for down_counter_reload
module tb_down_counter_reload;

  localparam int W  = 4;
  localparam int PS = 4;

  logic         clk = 1'b0;
  logic         reset, load, enable, auto_reload;
  logic [W-1:0] data_in;
  logic [W-1:0] count;
  logic         zero, tc_pulse, busy;

  int n_checks = 0;
  int n_fail   = 0;

  down_counter_reload #(.WIDTH(W), .PRESCALE(PS)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in),
    .enable(enable), .auto_reload(auto_reload),
    .count(count), .zero(zero), .tc_pulse(tc_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: timer value, remembered period, whether a count is
  // in progress, and whether that count is currently advancing.
  int m_val, m_period, m_pre;
  bit m_active, m_advancing, m_tc;

  task automatic model_edge();
    m_tc = 0;
    if (reset) begin
      m_val = 0; m_period = 0; m_pre = 0; m_active = 0; m_advancing = 0;
    end else if (load) begin
      m_val = int'(data_in); m_period = int'(data_in); m_pre = 0;
      m_active = (data_in != 0);
      m_advancing = m_active && enable;
    end else if (m_active) begin
      if (!enable) begin
        m_advancing = 0;
      end else if (!m_advancing) begin
        m_advancing = 1;
      end else begin
        bit tick;
`ifdef PRESCALE_EN
        m_pre = m_pre + 1;
        tick = (m_pre == PS);
        if (tick) m_pre = 0;
`else
        tick = 1;
`endif
        if (tick) begin
          if (m_val == 1) begin
            m_tc = 1;
            if (auto_reload) m_val = m_period;
            else begin m_val = 0; m_active = 0; m_advancing = 0; end
          end else begin
            m_val = m_val - 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 32'(count), 32'(m_val));
    chk({tag, " zero"}, 32'(zero), 32'(m_val == 0));
    chk({tag, " tc_pulse"}, 32'(tc_pulse), 32'(m_tc));
    chk({tag, " busy"}, 32'(busy), 32'(m_active));
  endtask

  task automatic drive(input logic r, input logic l, input logic [W-1:0] d,
                       input logic e, input logic a);
    reset = r; load = l; data_in = d; enable = e; auto_reload = a;
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic         rst, ld;
    logic [W-1:0] din;
    logic         en, ar;
    logic [W-1:0] cnt;
    logic         tc, bsy, zr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ld, input logic [W-1:0] din,
                     input logic en, input logic ar, input logic [W-1:0] cnt,
                     input logic tc, input logic bsy);
    vec_t v;
    v.rst = rst; v.ld = ld; v.din = din; v.en = en; v.ar = ar;
    v.cnt = cnt; v.tc = tc; v.bsy = bsy; v.zr = (cnt == 0);
    vecs.push_back(v);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    #1;

    for (int i = 0; i < 10; i++) cycle("reset");

`ifndef PRESCALE_EN
    // Countdown, no reload
    add(0,1,5,1,0, 5,0,1); add(0,0,0,1,0, 4,0,1); add(0,0,0,1,0, 3,0,1);
    add(0,0,0,1,0, 2,0,1); add(0,0,0,1,0, 1,0,1); add(0,0,0,1,0, 0,1,0);
    add(0,0,0,1,0, 0,0,0); add(0,0,0,1,1, 0,0,0);
    // Auto-reload period 3
    add(0,1,3,1,1, 3,0,1); add(0,0,0,1,1, 2,0,1); add(0,0,0,1,1, 1,0,1);
    add(0,0,0,1,1, 3,1,1); add(0,0,0,1,1, 2,0,1); add(0,0,0,1,1, 1,0,1);
    add(0,0,0,1,1, 3,1,1);
    // Hold at 7, resume with one idle edge
    add(0,1,9,1,0, 9,0,1); add(0,0,0,1,0, 8,0,1); add(0,0,0,1,0, 7,0,1);
    add(0,0,0,0,0, 7,0,1); add(0,0,0,0,0, 7,0,1); add(0,0,0,0,0, 7,0,1);
    add(0,0,0,0,0, 7,0,1); add(0,0,0,1,0, 7,0,1); add(0,0,0,1,0, 6,0,1);
    add(0,0,0,1,0, 5,0,1);
    // Reset beats load; reload mid-count; load zero
    add(1,1,5,1,0, 0,0,0); add(0,1,3,1,0, 3,0,1); add(0,1,4'hA,1,0, 4'hA,0,1);
    add(0,1,0,1,0, 0,0,0); add(0,0,0,1,0, 0,0,0);
    // Load on terminal-count edge wins
    add(0,1,1,1,0, 1,0,1); add(0,1,6,1,0, 6,0,1);
    // N==1 with auto-reload pulses every enabled cycle
    add(0,1,1,1,1, 1,0,1); add(0,0,0,1,1, 1,1,1); add(0,0,0,1,1, 1,1,1);
    add(0,0,0,0,1, 1,0,1);
    // auto_reload only matters at the terminal edge
    add(0,1,2,1,1, 2,0,1); add(0,0,0,1,0, 1,0,1); add(0,0,0,1,1, 2,1,1);
    // Load without enable parks in HOLD
    add(0,1,4,0,0, 4,0,1); add(0,0,0,0,0, 4,0,1);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].din, vecs[i].en, vecs[i].ar);
      cycle("vec-model");
      chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d tc", i), 32'(tc_pulse), 32'(vecs[i].tc));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].zr));
    end

    // DONE holds zero for 20 cycles regardless of enable
    drive(0, 1, 2, 1, 0); cycle("done-load");
    drive(0, 0, 0, 1, 0); cycle("done-1"); cycle("done-2");
    chk("done tc", 32'(tc_pulse), 32'd1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, i[0], 0);
      cycle("done-hold");
      chk("done count", 32'(count), 32'd0);
      chk("done busy", 32'(busy), 32'd0);
    end
`else
    // Prescaled: load 2 gives 4 cycles of 2, 4 of 1, then 0 with tc
    drive(0, 1, 2, 1, 0); cycle("pre-load");
    chk("pre load count", 32'(count), 32'd2);
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle("pre-run");
      chk($sformatf("pre c%0d count", i), 32'(count), (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("pre c%0d tc", i), 32'(tc_pulse), (i == 8) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      d = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), d,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
